lock_status_display: RTL

Downstream status stage for the serial code lock. Consumes the lock's per-cycle progress code (`selsw`) and its unlock/lockout status levels. Drives a 4-LED progress bar, an active-low seven-segment character, a buzzer and a saturating count of successful opens. All outputs are registered, so the lock's combinational outputs never reach the pads directly.

---
 rtl/lock_status_display.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/lock_status_display.sv
// Registered status stage for the serial code lock: LED progress bar, seven-segment
// character, alarm buzzer and a saturating count of successful opens.
module lock_status_display #(
    parameter int unsigned BLINK_HALF  = 4,
    parameter int unsigned HOLD_CYCLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] selsw,
    input  logic       unlocked,
    input  logic       wrong,
    output logic [3:0] led,
    output logic [6:0] seg,
    output logic       buzzer,
    output logic [3:0] open_count
);

    localparam int unsigned CNT_W = 8;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_TWO   = 7'b0100100;
    localparam logic [6:0] SEG_THREE = 7'b0110000;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_OPEN  = 3'd2,
        S_ALARM = 3'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]   blink_q, blink_d;
    logic               blink_on_q, blink_on_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         led_q, led_d;
    logic [6:0]         seg_q, seg_d;
    logic               buzzer_q, buzzer_d;

    logic [2:0]         sel_v;
    logic [CNT_W-1:0]   hold_inc;
    logic [CNT_W-1:0]   blink_inc;

    // Next state, counters and registered output values
    always_comb begin
        state_d    = S_IDLE;
        hold_d     = '0;
        blink_d    = '0;
        blink_on_d = 1'b0;
        cnt_d      = cnt_q;
        led_d      = 4'b0000;
        seg_d      = SEG_DASH;
        buzzer_d   = 1'b0;

        // Progress codes 4..7 carry no digit and behave like "none"
        sel_v     = (selsw <= 3'd3) ? selsw : 3'd0;
        hold_inc  = hold_q + CNT_W'(1);
        blink_inc = blink_q + CNT_W'(1);

        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (wrong)               state_d = S_ALARM;
                else if (unlocked)       state_d = S_OPEN;
                else if (sel_v != 3'd0)  state_d = S_ENTRY;
                else                     state_d = S_IDLE;
            end
            S_OPEN: begin
                if (wrong)               state_d = S_ALARM;
                else if (unlocked)       state_d = S_OPEN;
                else if (sel_v != 3'd0)  state_d = S_ENTRY;
                else if (hold_inc >= CNT_W'(HOLD_CYCLES)) state_d = S_IDLE;
                else begin
                    state_d = S_OPEN;
                    hold_d  = hold_inc;
                end
            end
            S_ALARM: begin
                if (wrong) begin
                    state_d = S_ALARM;
                    if (blink_inc >= CNT_W'(BLINK_HALF)) begin
                        blink_d    = '0;
                        blink_on_d = ~blink_on_q;
                    end else begin
                        blink_d    = blink_inc;
                        blink_on_d = blink_on_q;
                    end
                end else if (unlocked) begin
                    state_d = S_OPEN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Any state change restarts both counters; alarm always starts in the ON phase
        if (state_d != state_q) begin
            hold_d     = '0;
            blink_d    = '0;
            blink_on_d = 1'b1;
        end

        if (state_d == S_OPEN && state_q != S_OPEN && cnt_q != 4'hF)
            cnt_d = cnt_q + 4'd1;

        case (state_d)
            S_ENTRY: begin
                case (sel_v)
                    3'd1:    begin led_d = 4'b0001; seg_d = SEG_ONE;   end
                    3'd2:    begin led_d = 4'b0011; seg_d = SEG_TWO;   end
                    3'd3:    begin led_d = 4'b0111; seg_d = SEG_THREE; end
                    default: begin led_d = 4'b0000; seg_d = SEG_DASH;  end
                endcase
            end
            S_OPEN: begin
                led_d = 4'b1111;
                seg_d = SEG_U;
            end
            S_ALARM: begin
                led_d    = {4{blink_on_d}};
                seg_d    = SEG_E;
                buzzer_d = blink_on_d;
            end
            default: begin
                led_d = 4'b0000;
                seg_d = SEG_DASH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            blink_q    <= '0;
            blink_on_q <= 1'b0;
            cnt_q      <= '0;
            led_q      <= 4'b0000;
            seg_q      <= SEG_DASH;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            blink_q    <= blink_d;
            blink_on_q <= blink_on_d;
            cnt_q      <= cnt_d;
            led_q      <= led_d;
            seg_q      <= seg_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign led        = led_q;
    assign seg        = seg_q;
    assign buzzer     = buzzer_q;
    assign open_count = cnt_q;

endmodule
